spi_sram_responder: RTL and testbench

SPI_SRAM_RESPONDER -- requirements
Module: spi_sram_responder

---
 rtl/spi_sram_responder.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_sram_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_responder.sv
// SPI mode-0 responder in front of a byte-wide store: 0x03 = sequential read, 0x02 = sequential write,
// 16-bit address, all SPI pins oversampled through synchronizers on the system clock.
module spi_sram_responder #(
   parameter int DEPTH       = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic CLK,
   input  logic CS_N,
   input  logic MOSI,
   output logic MISO,
   output logic MISO_OE,
   output logic busy,
   output logic wr_strobe
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR_HI,
      ADDR_LO,
      READ,
      WRITE,
      IGNORE
   } state_t;

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_cs_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_clk_prev;
   logic                   r_cs_prev;

   state_t                 r_state;
   logic [2:0]             r_bit_cnt;
   logic [6:0]             r_rx;
   logic [7:0]             r_tx;
   logic [2:0]             r_tx_cnt;
   logic [7:0]             r_addr_hi;
   logic [AW-1:0]          r_addr;
   logic                   r_is_read;
   logic                   r_load;
   logic [7:0]             r_mem [DEPTH];

   logic                   w_clk_s;
   logic                   w_cs_s;
   logic                   w_mosi_s;
   logic                   w_clk_rise;
   logic                   w_clk_fall;
   logic                   w_cs_rise;
   logic                   w_cs_fall;
   logic [7:0]             w_rx_next;
   logic                   w_byte_done;
   logic                   w_we;

   // CS_N synchronizer resets to the inactive (high) level so reset release never looks like a select.
   // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clk_sync  <= '0;
         r_cs_sync   <= '1;
         r_mosi_sync <= '0;
         r_clk_prev  <= 1'b0;
         r_cs_prev   <= 1'b1;
      end else begin
         r_clk_sync[0]  <= CLK;
         r_cs_sync[0]   <= CS_N;
         r_mosi_sync[0] <= MOSI;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_clk_sync[i]  <= r_clk_sync[i-1];
            r_cs_sync[i]   <= r_cs_sync[i-1];
            r_mosi_sync[i] <= r_mosi_sync[i-1];
         end
         r_clk_prev <= w_clk_s;
         r_cs_prev  <= w_cs_s;
      end
   end

   assign w_clk_s     = r_clk_sync[SYNC_STAGES-1];
   assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_clk_rise  = w_clk_s & ~r_clk_prev;
   assign w_clk_fall  = ~w_clk_s & r_clk_prev;
   assign w_cs_rise   = w_cs_s & ~r_cs_prev;
   assign w_cs_fall   = ~w_cs_s & r_cs_prev;
   assign w_rx_next   = {r_rx, w_mosi_s};
   assign w_byte_done = w_clk_rise && (r_bit_cnt == 3'd7);

   // Not gated by the CS_N rising edge, so a byte whose last bit lands with deselect still commits.
   assign w_we = (r_state == WRITE) && w_byte_done;

   // NOTE: the store has no reset; its contents survive reset and a reset branch would block RAM inference.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[r_addr] <= w_rx_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_bit_cnt <= 3'd0;
         r_rx      <= 7'd0;
         r_tx      <= 8'd0;
         r_tx_cnt  <= 3'd0;
         r_addr_hi <= 8'd0;
         r_addr    <= '0;
         r_is_read <= 1'b0;
         r_load    <= 1'b0;
         MISO      <= 1'b0;
         MISO_OE   <= 1'b0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
      end else begin
         busy      <= ~w_cs_s;
         wr_strobe <= w_we;
         r_load    <= 1'b0;
         if (r_load) begin
            r_tx <= r_mem[r_addr];
         end

         if (r_state != IDLE && w_cs_rise) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            MISO      <= 1'b0;
            MISO_OE   <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (w_cs_fall) begin
                     r_state   <= CMD;
                     r_bit_cnt <= 3'd0;
                     r_rx      <= 7'd0;
                  end
               end

               CMD: begin
                  if (w_clk_rise) begin
                     r_rx      <= w_rx_next[6:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_byte_done) begin
                        case (w_rx_next)
                           8'h03: begin
                              r_is_read <= 1'b1;
                              r_state   <= ADDR_HI;
                           end
                           8'h02: begin
                              r_is_read <= 1'b0;
                              r_state   <= ADDR_HI;
                           end
                           default: r_state <= IGNORE;
                        endcase
                     end
                  end
               end

               ADDR_HI: begin
                  if (w_clk_rise) begin
                     r_rx      <= w_rx_next[6:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_byte_done) begin
                        r_addr_hi <= w_rx_next;
                        r_state   <= ADDR_LO;
                     end
                  end
               end

               ADDR_LO: begin
                  if (w_clk_rise) begin
                     r_rx      <= w_rx_next[6:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_byte_done) begin
                        r_addr <= AW'({r_addr_hi, w_rx_next});
                        if (r_is_read) begin
                           r_state  <= READ;
                           r_load   <= 1'b1;
                           r_tx_cnt <= 3'd0;
                           MISO_OE  <= 1'b1;
                        end else begin
                           r_state <= WRITE;
                        end
                     end
                  end
               end

               // The 8th falling edge fetches the next byte so its MSB is ready for the 9th.
               READ: begin
                  if (w_clk_fall) begin
                     MISO     <= r_tx[7];
                     r_tx     <= {r_tx[6:0], 1'b0};
                     r_tx_cnt <= r_tx_cnt + 3'd1;
                     if (r_tx_cnt == 3'd7) begin
                        r_addr <= r_addr + AW'(1);
                        r_load <= 1'b1;
                     end
                  end
               end

               WRITE: begin
                  if (w_clk_rise) begin
                     r_rx      <= w_rx_next[6:0];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_byte_done) begin
                        r_addr <= r_addr + AW'(1);
                     end
                  end
               end

               IGNORE: begin
                  r_bit_cnt <= 3'd0;
               end

               default: r_state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: table of single-byte write/readback vectors plus
// hand-written burst, wrap, ignore, abort, coincident-deselect and reset sequences.
module tb_spi_sram_responder;

   localparam int HALF = 8;

   logic clk;
   logic reset;
   logic CLK;
   logic CS_N;
   logic MOSI;
   logic MISO;
   logic MISO_OE;
   logic busy;
   logic wr_strobe;

   int total = 0;
   int bad   = 0;

   int strobe_cnt = 0;
   int oe_cnt     = 0;
   int miso_cnt   = 0;
   int viol_cnt   = 0;

   spi_sram_responder #(
      .DEPTH       (1024),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .CLK       (CLK),
      .CS_N      (CS_N),
      .MOSI      (MOSI),
      .MISO      (MISO),
      .MISO_OE   (MISO_OE),
      .busy      (busy),
      .wr_strobe (wr_strobe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (wr_strobe)         strobe_cnt <= strobe_cnt + 1;
      if (MISO_OE)           oe_cnt     <= oe_cnt + 1;
      if (MISO)              miso_cnt   <= miso_cnt + 1;
      if (MISO && !MISO_OE)  viol_cnt   <= viol_cnt + 1;
   end

   typedef struct {
      logic [15:0] wr_addr;
      logic [7:0]  wr_data;
      logic [15:0] rd_addr;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      MOSI = b;
      tick(HALF);
      r = MISO;
      CLK = 1'b1;
      tick(HALF);
      CLK = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
      logic b;
      rx = 8'h00;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(tx[i], b);
         rx = {rx[6:0], b};
      end
   endtask

   task automatic sel();
      CS_N = 1'b0;
      tick(HALF);
   endtask

   task automatic desel();
      tick(HALF);
      CS_N = 1'b1;
      tick(2 * HALF);
   endtask

   task automatic start_cmd(input logic [7:0] cmd, input logic [15:0] addr);
      logic [7:0] rx;
      sel();
      spi_byte(cmd, rx);
      spi_byte(addr[15:8], rx);
      spi_byte(addr[7:0], rx);
   endtask

   task automatic write1(input logic [15:0] addr, input logic [7:0] data);
      logic [7:0] rx;
      start_cmd(8'h02, addr);
      spi_byte(data, rx);
      desel();
   endtask

   task automatic read1(input logic [15:0] addr, output logic [7:0] data);
      start_cmd(8'h03, addr);
      spi_byte(8'h00, data);
      desel();
   endtask

   initial begin
      logic [7:0]  rx;
      logic [31:0] stream;
      logic        b;
      int          s0;
      int          o0;
      int          m0;

      vecs[0] = '{16'h0010, 8'hA5, 16'h0010, 8'hA5};
      vecs[1] = '{16'h0411, 8'h3C, 16'h0011, 8'h3C};
      vecs[2] = '{16'h03FF, 8'h5A, 16'h03FF, 8'h5A};
      vecs[3] = '{16'h0000, 8'hC3, 16'h0400, 8'hC3};
      vecs[4] = '{16'h0200, 8'hFF, 16'h0200, 8'hFF};
      vecs[5] = '{16'h0030, 8'h6E, 16'h0030, 8'h6E};

      reset = 1'b0;
      CLK   = 1'b0;
      CS_N  = 1'b1;
      MOSI  = 1'b0;
      tick(5);
      check("reset MISO", MISO, 0);
      check("reset MISO_OE", MISO_OE, 0);
      check("reset busy", busy, 0);
      check("reset wr_strobe", wr_strobe, 0);
      reset = 1'b1;
      tick(5);

      for (int i = 0; i < 6; i++) begin
         s0 = strobe_cnt;
         write1(vecs[i].wr_addr, vecs[i].wr_data);
         check($sformatf("vec%0d strobes", i), strobe_cnt - s0, 1);
         read1(vecs[i].rd_addr, rx);
         check($sformatf("vec%0d readback", i), rx, vecs[i].exp);
      end

      // Burst write then 32-bit sequential read.
      s0 = strobe_cnt;
      start_cmd(8'h02, 16'h0020);
      check("busy in transfer", busy, 1);
      spi_byte(8'h11, rx);
      spi_byte(8'h22, rx);
      spi_byte(8'h33, rx);
      spi_byte(8'h44, rx);
      desel();
      check("burst write strobes", strobe_cnt - s0, 4);
      check("busy after deselect", busy, 0);
      start_cmd(8'h03, 16'h0020);
      check("MISO_OE in read", MISO_OE, 1);
      stream = 32'h0;
      for (int i = 0; i < 4; i++) begin
         spi_byte(8'h00, rx);
         stream = {stream[23:0], rx};
      end
      desel();
      check("burst read stream", stream, 32'h11223344);
      check("MISO_OE after read", MISO_OE, 0);

      // Read across the top of the store.
      start_cmd(8'h03, 16'h03FF);
      stream = 32'h0;
      for (int i = 0; i < 2; i++) begin
         spi_byte(8'h00, rx);
         stream = {stream[23:0], rx};
      end
      desel();
      check("read wrap", stream, 32'h00005AC3);

      // Write across the top of the store.
      s0 = strobe_cnt;
      start_cmd(8'h02, 16'h03FF);
      spi_byte(8'h77, rx);
      spi_byte(8'h88, rx);
      desel();
      check("write wrap strobes", strobe_cnt - s0, 2);
      read1(16'h0000, rx);
      check("write wrap mem[0]", rx, 8'h88);
      read1(16'h03FF, rx);
      check("write wrap mem[3FF]", rx, 8'h77);

      // Unknown command: consumed silently.
      s0 = strobe_cnt;
      o0 = oe_cnt;
      m0 = miso_cnt;
      stream = 32'h0;
      sel();
      spi_byte(8'h05, rx);
      spi_byte(8'hAA, rx);
      stream[23:16] = rx;
      spi_byte(8'h55, rx);
      stream[15:8] = rx;
      spi_byte(8'hFF, rx);
      stream[7:0] = rx;
      desel();
      check("ignore strobes", strobe_cnt - s0, 0);
      check("ignore MISO_OE cycles", oe_cnt - o0, 0);
      check("ignore MISO high cycles", miso_cnt - m0, 0);
      check("ignore sampled MISO", stream, 0);

      // Write aborted after 5 data bits.
      s0 = strobe_cnt;
      start_cmd(8'h02, 16'h0030);
      for (int i = 0; i < 5; i++) spi_bit(1'b1, b);
      desel();
      check("abort strobes", strobe_cnt - s0, 0);
      read1(16'h0030, rx);
      check("abort store unchanged", rx, 8'h6E);

      // Deselect on the same edge as the 8th data bit: byte still commits.
      s0 = strobe_cnt;
      start_cmd(8'h02, 16'h0040);
      for (int i = 7; i >= 1; i--) spi_bit(8'hB7 >> i, b);
      MOSI = 1'b1;
      tick(HALF);
      CLK  = 1'b1;
      CS_N = 1'b1;
      tick(HALF);
      CLK  = 1'b0;
      tick(2 * HALF);
      check("coincident deselect strobes", strobe_cnt - s0, 1);

      // SPI clocks while deselected are ignored.
      s0 = strobe_cnt;
      for (int i = 0; i < 24; i++) spi_bit(i[0], b);
      tick(HALF);
      check("deselected clocks strobes", strobe_cnt - s0, 0);
      check("deselected clocks busy", busy, 0);
      read1(16'h0040, rx);
      check("coincident deselect data", rx, 8'hB7);

      // Reset during the low address byte.
      sel();
      spi_byte(8'h02, rx);
      spi_byte(8'h00, rx);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, b);
      check("busy before reset", busy, 1);
      reset = 1'b0;
      #1;
      check("outputs in reset", {MISO, MISO_OE, busy, wr_strobe}, 0);
      tick(2);
      CS_N = 1'b1;
      CLK  = 1'b0;
      tick(HALF);
      reset = 1'b1;
      tick(HALF);
      s0 = strobe_cnt;
      write1(16'h0001, 8'h9D);
      check("post-reset write strobes", strobe_cnt - s0, 1);
      read1(16'h0001, rx);
      check("post-reset readback", rx, 8'h9D);

      check("MISO high while MISO_OE low", viol_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
